// File: rtl/hexa_anim_ctrl.sv
// hexa_anim_ctrl
// Upstream controller for one hexadecimal 7-segment decoder digit. It shows a
// latched 4-bit value, a rotating single-segment "busy" animation, or a
// blink sequence after an error, and drives the decoder's 5-bit code input.
//
// Ports:
//   clock   in   system clock, all state changes on the rising edge
//   reset   in   synchronous, active-high reset
//   load    in   one-cycle pulse: latch valor (honoured in every state)
//   valor   in   [3:0] hex value to display
//   busy    in   level: run the spin animation while high
//   erro    in   one-cycle pulse: start (or restart) the error blink sequence
//   sentido in   spin direction, 0 = forward, 1 = reverse
//                (only present when HEXA_SPIN_DIR_EN is defined)
//   codigo  out  [4:0] decoder code: 00-0F digit, 10-15 single segment, 1F blank
//   pronto  out  one-cycle pulse when a blink sequence completes
//   tick    out  one-cycle prescaler pulse (animation step strobe)
//
// Parameters:
//   TICK_DIV     clock cycles per animation step (>= 2)
//   BLINK_STEPS  full off/on blink cycles in the error sequence (>= 1)
//
// Optional feature macro: HEXA_SPIN_DIR_EN (adds the sentido input).

module hexa_anim_ctrl #(
    parameter int TICK_DIV    = 5000000,
    parameter int BLINK_STEPS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] valor,
    input  logic       busy,
    input  logic       erro,
`ifdef HEXA_SPIN_DIR_EN
    input  logic       sentido,
`endif
    output logic [4:0] codigo,
    output logic       pronto,
    output logic       tick
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int BW = $clog2(2 * BLINK_STEPS);
    localparam logic [PW-1:0] PMAX  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PONE  = PW'(1);
    localparam logic [BW-1:0] BLAST = BW'(2 * BLINK_STEPS - 1);
    localparam logic [BW-1:0] BONE  = BW'(1);

    typedef enum logic [1:0] {
        APAGADO,
        MOSTRA,
        GIRA,
        PISCA
    } state_t;

    state_t        state;
    logic [3:0]    valor_reg;
    logic [2:0]    fase;
    logic          vis;
    logic [PW-1:0] presc;
    logic [BW-1:0] bcnt;
    logic [PW-1:0] presc_nxt;
    logic          rev;

`ifdef HEXA_SPIN_DIR_EN
    assign rev = sentido;
`else
    assign rev = 1'b0;
`endif

    // One step around the six outer segments, either direction.
    function automatic logic [2:0] fase_step(input logic [2:0] f, input logic r);
        if (r)
            return (f == 3'd0) ? 3'd5 : f - 3'd1;
        else
            return (f == 3'd5) ? 3'd0 : f + 3'd1;
    endfunction

    assign tick      = (presc == PMAX);
    assign presc_nxt = tick ? '0 : presc + PONE;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= APAGADO;
            valor_reg <= 4'h0;
            fase      <= 3'd0;
            vis       <= 1'b0;
            presc     <= '0;
            bcnt      <= '0;
            pronto    <= 1'b0;
        end else begin
            pronto <= 1'b0;
            if (load)
                valor_reg <= valor;

            if (erro) begin
                // Entering PISCA, or restarting it, always begins blanked.
                state <= PISCA;
                vis   <= 1'b0;
                bcnt  <= '0;
                presc <= '0;
            end else begin
                case (state)
                    APAGADO: begin
                        if (busy) begin
                            state <= GIRA;
                            fase  <= 3'd0;
                            presc <= '0;
                        end else if (load) begin
                            state <= MOSTRA;
                            presc <= '0;
                        end else begin
                            presc <= presc_nxt;
                        end
                    end
                    MOSTRA: begin
                        if (busy) begin
                            state <= GIRA;
                            fase  <= 3'd0;
                            presc <= '0;
                        end else begin
                            presc <= presc_nxt;
                        end
                    end
                    GIRA: begin
                        // fase is left as-is on exit; the next entry clears it.
                        if (!busy) begin
                            state <= MOSTRA;
                            presc <= '0;
                        end else begin
                            presc <= presc_nxt;
                            if (tick)
                                fase <= fase_step(fase, rev);
                        end
                    end
                    PISCA: begin
                        // Finish on the tick that ends the last visible half-period.
                        if (tick && bcnt == BLAST) begin
                            state  <= MOSTRA;
                            pronto <= 1'b1;
                            presc  <= '0;
                        end else begin
                            presc <= presc_nxt;
                            if (tick) begin
                                vis  <= ~vis;
                                bcnt <= bcnt + BONE;
                            end
                        end
                    end
                    default: begin
                        state <= APAGADO;
                        presc <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        codigo = 5'h1F;
        case (state)
            APAGADO: codigo = 5'h1F;
            MOSTRA:  codigo = {1'b0, valor_reg};
            GIRA:    codigo = 5'h10 + {2'b00, fase};
            PISCA:   codigo = vis ? {1'b0, valor_reg} : 5'h1F;
            default: codigo = 5'h1F;
        endcase
    end

endmodule
